jtgng_rom_arb: RTL and testbench
================================

# jtgng_rom_arb

Round-robin arbiter that shares the single SDRAM read port (`sdram_req`/`sdram_addr`/`sdram_ack`/`data_rdy`/`data_read` of `jtgng_sdram`) among NREQ ROM requesters inside a `*_game` core (main CPU, sound CPU, char, scroll, object fetchers). It sequences one read at a time, routes returned data to the winner with a one-cycle `ok` pulse, and gates SDRAM refresh into idle slots. It stops all traffic while ROM download is active and flags lost transactions with a watchdog.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 22, SDRAM word-address width
- DW, 32, read data width
- TIMEOUT, 255, max cycles from issue to `data_rdy` before abort (8-bit counter)

- clk  in  1  system clock (48 MHz)
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- downloading  in  1  ROM download in progress; holds arbiter idle
- req  in  NREQ  request level per requester
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- rd_data  out  DW  data of last completed read, shared by all requesters
- ok  out  NREQ  one-hot, one-cycle completion strobe
- sdram_req  out  1  read request to SDRAM controller
- sdram_addr  out  AW  latched address of current transaction
- sdram_ack  in  1  controller accepted request
- data_rdy  in  1  `data_read` valid
- data_read  in  DW  SDRAM read data
- refresh_en  out  1  refresh permitted this cycle
- busy  out  1  transaction in flight (ISSUE/WAIT/DONE)
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if `downloading`=0 and any `req` high, pick winner = first set bit searching from `last+1` upward with wrap; latch index into `cur`, `addr[cur]` into `sdram_addr`, set `last`=cur, go ISSUE.
- ISSUE: `sdram_req`=1 until `sdram_ack` sampled high, then `sdram_req`=0, go WAIT. `data_rdy` ignored in ISSUE.
- WAIT: on `data_rdy`, register `data_read` into `rd_data`, go DONE. `sdram_ack` ignored.
- DONE: `ok[cur]`=1 for exactly this cycle, `rd_data` valid; next state IDLE.
- Requester rule: hold `req` high and `addr` stable until `ok`; at the edge where `ok` is seen, either drop `req` or present a new address (new request). Any `req` high in an IDLE cycle counts as a request.
- `refresh_en` (registered) = 1 in IDLE when no `req` bit is high and `downloading`=0; 0 otherwise.
- Watchdog: 8-bit counter cleared on entry to ISSUE, increments in ISSUE/WAIT; reaching TIMEOUT → IDLE, `sdram_req`=0, no `ok`, `timeout_err`=1 (cleared only by `rst`), `last` stays = cur so others are served next.
- `downloading` high: next edge forces IDLE from any state, `sdram_req`=0, `ok`=0, in-flight data discarded; `rd_data`, `last` retained.
- `rst`: state IDLE, `last`=NREQ-1 (requester 0 wins first), counter 0; all outputs 0.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Minimum latency: `req` high in IDLE cycle t → `sdram_req` t+1; `sdram_ack` in t+1 → WAIT t+2; `data_rdy` in t+2 → `ok` at t+3. Earliest re-arbitration t+4.
- Throughput with zero-wait controller: one read per 4 cycles.
- Simultaneous requests: strictly rotating; with all NREQ held high each is served once per NREQ transactions.
- `sdram_addr` stable from ISSUE entry until next arbitration.

## Structure
- Package `jtgng_rom_arb_pkg`: state enum (IDLE, ISSUE, WAIT, DONE), watchdog width constant.
- Sub-module `jtgng_rr_pick`: combinational round-robin picker (req, last → valid, index); verified standalone.

## Test plan
- Single request: req=4'b0001, addr0=22'h01234, ack 1 cycle after issue, data_rdy 2 cycles later with 32'hDEADBEEF → sdram_addr=22'h01234, ok=4'b0001 for one cycle, rd_data=32'hDEADBEEF.
- All four requests held, 8 transactions → ok order 0,1,2,3,0,1,2,3; sdram_addr matches each winner.
- Minimum latency: ack and data_rdy at earliest cycles → ok exactly 3 cycles after req; refresh_en=0 throughout, 1 in first idle cycle with req=0.
- Watchdog: data_rdy never asserted → after 255 cycles state IDLE, timeout_err=1, no ok, next winner is requester 1.
- downloading raised in WAIT → next cycle IDLE, sdram_req=0; later data_rdy produces no ok; after downloading drops arbitration resumes.
- rst asserted mid-ISSUE (asynchronously, off clock edge) → sdram_req, ok, busy, refresh_en, timeout_err immediately 0; after release requester 0 wins first.

Source files
------------

// File: rtl/jtgng_rom_arb_pkg.sv
// Shared types for the ROM arbiter: FSM state encoding and watchdog width.
package jtgng_rom_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } arb_state_e;

   localparam int WD_W = 8;

endpackage

// File: rtl/jtgng_rom_arb_if.sv
// SDRAM read-port bundle between the ROM arbiter (master) and jtgng_sdram (slave).
interface jtgng_rom_arb_if #(
   parameter int AW = 22,
   parameter int DW = 32
);
   // sdram_req holds until sdram_ack is sampled high on a rising edge, which
   // consumes the request; data_rdy qualifies data_read for that single cycle
   // and is only honoured while a read is outstanding.
   logic          sdram_req;
   logic [AW-1:0] sdram_addr;
   logic          sdram_ack;
   logic          data_rdy;
   logic [DW-1:0] data_read;

   modport master (
      output sdram_req, sdram_addr,
      input  sdram_ack, data_rdy, data_read
   );

   modport slave (
      input  sdram_req, sdram_addr,
      output sdram_ack, data_rdy, data_read
   );

endinterface

// File: rtl/jtgng_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module jtgng_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   index
);

   logic [IW-1:0] cand;

   // Walk the offsets from farthest to nearest so the nearest hit is kept.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/jtgng_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among NREQ ROM requesters,
// with refresh gating, download hold-off and a transaction watchdog.
module jtgng_rom_arb
   import jtgng_rom_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int AW      = 22,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               downloading,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] addr,
   output logic [DW-1:0]      rd_data,
   output logic [NREQ-1:0]    ok,
   jtgng_rom_arb_if.master    sdram,
   output logic               refresh_en,
   output logic               busy,
   output logic               timeout_err,
   output arb_state_e         state_dbg
);

   localparam int IW = $clog2(NREQ);

   arb_state_e      state, state_nx;
   logic [IW-1:0]   cur, cur_nx, last, last_nx;
   logic [WD_W-1:0] wd_cnt, wd_cnt_nx;
   logic            wd_hit;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic [AW-1:0]   addr_nx;
   logic [DW-1:0]   rd_nx;
   logic [NREQ-1:0] ok_nx;
   logic            sreq_nx, busy_nx, refresh_nx, terr_nx;

   jtgng_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .last  (last),
      .valid (pick_valid),
      .index (pick_idx)
   );

   assign state_dbg = state;
   assign wd_hit    = (wd_cnt == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_nx  = state;
      cur_nx    = cur;
      last_nx   = last;
      wd_cnt_nx = wd_cnt;
      addr_nx   = sdram.sdram_addr;
      rd_nx     = rd_data;
      ok_nx     = '0;
      terr_nx   = timeout_err;
      if (downloading) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_nx  = ST_ISSUE;
                  cur_nx    = pick_idx;
                  last_nx   = pick_idx;
                  addr_nx   = addr[int'(pick_idx)*AW +: AW];
                  wd_cnt_nx = '0;
               end
            end
            ST_ISSUE: begin
               // An aborted read leaves `last` on the loser so others go next.
               if (wd_hit) begin
                  state_nx = ST_IDLE;
                  terr_nx  = 1'b1;
               end else begin
                  wd_cnt_nx = wd_cnt + 1'b1;
                  if (sdram.sdram_ack) state_nx = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wd_hit) begin
                  state_nx = ST_IDLE;
                  terr_nx  = 1'b1;
               end else begin
                  wd_cnt_nx = wd_cnt + 1'b1;
                  if (sdram.data_rdy) begin
                     state_nx = ST_DONE;
                     rd_nx    = sdram.data_read;
                     ok_nx    = NREQ'(1) << cur;
                  end
               end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
      sreq_nx    = (state_nx == ST_ISSUE);
      busy_nx    = (state_nx != ST_IDLE);
      refresh_nx = (state == ST_IDLE) && !(|req) && !downloading;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         cur              <= '0;
         last             <= IW'(NREQ - 1);
         wd_cnt           <= '0;
         sdram.sdram_req  <= 1'b0;
         sdram.sdram_addr <= '0;
         rd_data          <= '0;
         ok               <= '0;
         refresh_en       <= 1'b0;
         busy             <= 1'b0;
         timeout_err      <= 1'b0;
      end else begin
         state            <= state_nx;
         cur              <= cur_nx;
         last             <= last_nx;
         wd_cnt           <= wd_cnt_nx;
         sdram.sdram_req  <= sreq_nx;
         sdram.sdram_addr <= addr_nx;
         rd_data          <= rd_nx;
         ok               <= ok_nx;
         refresh_en       <= refresh_nx;
         busy             <= busy_nx;
         timeout_err      <= terr_nx;
      end
   end

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Bench for jtgng_rom_arb: transaction-level reference with randomized requesters and SDRAM timing.
module tb_jtgng_rom_arb;
   import jtgng_rom_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int AW      = 22;
   localparam int DW      = 32;
   localparam int TIMEOUT = 255;
   localparam int M_DROP  = 0;
   localparam int M_KEEP  = 1;
   localparam int M_RAND  = 2;

   logic               clk_sys;
   logic               rst;
   logic               downloading;
   logic [NREQ-1:0]    req_v;
   logic [AW-1:0]      addr_v [NREQ];
   logic [NREQ*AW-1:0] addr_bus;
   logic [DW-1:0]      rd_data;
   logic [NREQ-1:0]    ok;
   logic               refresh_en;
   logic               busy;
   logic               timeout_err;
   arb_state_e         state_dbg;

   jtgng_rom_arb_if #(.AW(AW), .DW(DW)) sdram_bus ();

   jtgng_rom_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk_sys),
      .rst         (rst),
      .downloading (downloading),
      .req         (req_v),
      .addr        (addr_bus),
      .rd_data     (rd_data),
      .ok          (ok),
      .sdram       (sdram_bus),
      .refresh_en  (refresh_en),
      .busy        (busy),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   always_comb begin
      addr_bus = '0;
      for (int i = 0; i < NREQ; i++) addr_bus[i*AW +: AW] = addr_v[i];
   end

   // Clock / reset
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Scoreboard and reference state
   logic [DW-1:0] exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            m_last;
   logic          m_terr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_rd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   task automatic check_cycle(input string tag, input logic e_req, input logic e_busy,
                              input logic [NREQ-1:0] e_ok, input logic e_rf);
      chk({tag, " sdram_req"},   64'(sdram_bus.sdram_req),  64'(e_req));
      chk({tag, " busy"},        64'(busy),                 64'(e_busy));
      chk({tag, " ok"},          64'(ok),                   64'(e_ok));
      chk({tag, " refresh_en"},  64'(refresh_en),           64'(e_rf));
      chk({tag, " timeout_err"}, 64'(timeout_err),          64'(m_terr));
      chk({tag, " sdram_addr"},  64'(sdram_bus.sdram_addr), 64'(m_addr));
   endtask

   // Driver tasks
   task automatic do_reset();
      req_v       = '0;
      downloading = 1'b0;
      sdram_bus.sdram_ack = 1'b0;
      sdram_bus.data_rdy  = 1'b0;
      sdram_bus.data_read = '0;
      @(negedge clk_sys);
      rst = 1'b1;
      repeat (2) @(negedge clk_sys);
      rst = 1'b0;
      m_last = NREQ - 1;
      m_terr = 1'b0;
      m_addr = '0;
      m_rd   = '0;
      exp_q.delete();
      check_cycle("reset", 1'b0, 1'b0, '0, 1'b0);
      chk("reset rd_data", 64'(rd_data), 64'(0));
      chk("reset state", 64'(state_dbg), 64'(ST_IDLE));
   endtask

   // Called at the falling edge of an idle cycle with at least one request driven.
   task automatic run_one(input int ack_dly, input int rdy_dly, input logic [DW-1:0] dat, input int mode);
      int win;
      win = rr_next(req_v, m_last);
      if (win < 0) return;
      m_last = win;
      m_addr = addr_v[win];
      for (int i = 0; i <= ack_dly; i++) begin
         @(negedge clk_sys);
         check_cycle("issue", 1'b1, 1'b1, '0, 1'b0);
         sdram_bus.sdram_ack = (i == ack_dly);
         sdram_bus.data_rdy  = 1'($urandom_range(0, 1));
         sdram_bus.data_read = $urandom;
      end
      for (int i = 0; i <= rdy_dly; i++) begin
         @(negedge clk_sys);
         check_cycle("wait", 1'b0, 1'b1, '0, 1'b0);
         sdram_bus.sdram_ack = 1'($urandom_range(0, 1));
         sdram_bus.data_rdy  = (i == rdy_dly);
         sdram_bus.data_read = (i == rdy_dly) ? dat : $urandom;
      end
      exp_q.push_back(dat);
      @(negedge clk_sys);
      check_cycle("done", 1'b0, 1'b1, NREQ'(1) << win, 1'b0);
      chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      m_rd = dat;
      sdram_bus.sdram_ack = 1'b0;
      sdram_bus.data_rdy  = 1'b0;
      if (mode == M_KEEP || (mode == M_RAND && $urandom_range(0, 1) == 1))
         addr_v[win] = AW'($urandom);
      else
         req_v[win] = 1'b0;
      if (mode == M_RAND)
         for (int j = 0; j < NREQ; j++)
            if (!req_v[j] && j != win && $urandom_range(0, 3) == 0) begin
               req_v[j]  = 1'b1;
               addr_v[j] = AW'($urandom);
            end
      @(negedge clk_sys);
      check_cycle("idle", 1'b0, 1'b0, '0, 1'b0);
      if (req_v == '0) begin
         @(negedge clk_sys);
         check_cycle("idle_refresh", 1'b0, 1'b0, '0, 1'b1);
      end
   endtask

   initial begin
      int win;
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) addr_v[i] = '0;
      do_reset();

      // Single request from requester 0
      req_v     = 4'b0001;
      addr_v[0] = 22'h01234;
      run_one(1, 1, 32'hDEADBEEF, M_DROP);

      // All requesters held: strict rotation starting at 0
      do_reset();
      req_v = '1;
      for (int i = 0; i < NREQ; i++) addr_v[i] = AW'($urandom);
      for (int n = 0; n < 8; n++) run_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, M_KEEP);

      // Minimum latency, then refresh in the first empty idle cycle
      do_reset();
      req_v     = 4'b0100;
      addr_v[2] = AW'($urandom);
      run_one(0, 0, $urandom, M_DROP);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         if (req_v == '0) begin
            req_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) addr_v[i] = AW'($urandom);
         end
         run_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom, M_RAND);
      end

      // Watchdog: data never returns
      do_reset();
      req_v = 4'b0011;
      for (int i = 0; i < NREQ; i++) addr_v[i] = AW'($urandom);
      win    = rr_next(req_v, m_last);
      m_last = win;
      m_addr = addr_v[win];
      @(negedge clk_sys);
      check_cycle("wd_issue", 1'b1, 1'b1, '0, 1'b0);
      sdram_bus.sdram_ack = 1'b1;
      @(negedge clk_sys);
      check_cycle("wd_wait", 1'b0, 1'b1, '0, 1'b0);
      sdram_bus.sdram_ack = 1'b0;
      repeat (TIMEOUT - 2) begin
         @(negedge clk_sys);
         check_cycle("wd_wait", 1'b0, 1'b1, '0, 1'b0);
      end
      @(negedge clk_sys);
      m_terr = 1'b1;
      check_cycle("wd_abort", 1'b0, 1'b0, '0, 1'b0);
      run_one(0, 1, $urandom, M_DROP);

      // Download raised while waiting for data
      win    = rr_next(req_v, m_last);
      m_last = win;
      m_addr = addr_v[win];
      @(negedge clk_sys);
      check_cycle("dl_issue", 1'b1, 1'b1, '0, 1'b0);
      sdram_bus.sdram_ack = 1'b1;
      @(negedge clk_sys);
      check_cycle("dl_wait", 1'b0, 1'b1, '0, 1'b0);
      sdram_bus.sdram_ack = 1'b0;
      downloading = 1'b1;
      @(negedge clk_sys);
      check_cycle("dl_abort", 1'b0, 1'b0, '0, 1'b0);
      sdram_bus.data_rdy  = 1'b1;
      sdram_bus.data_read = $urandom;
      @(negedge clk_sys);
      check_cycle("dl_late", 1'b0, 1'b0, '0, 1'b0);
      chk("dl rd_data kept", 64'(rd_data), 64'(m_rd));
      sdram_bus.data_rdy = 1'b0;
      repeat (3) begin
         @(negedge clk_sys);
         check_cycle("dl_hold", 1'b0, 1'b0, '0, 1'b0);
      end
      downloading = 1'b0;
      run_one(1, 0, $urandom, M_DROP);

      // Asynchronous reset in the middle of an issue
      req_v = '1;
      for (int i = 0; i < NREQ; i++) addr_v[i] = AW'($urandom);
      @(negedge clk_sys);
      #2 rst = 1'b1;
      #1;
      chk("arst sdram_req", 64'(sdram_bus.sdram_req), 64'(0));
      chk("arst ok", 64'(ok), 64'(0));
      chk("arst busy", 64'(busy), 64'(0));
      chk("arst refresh_en", 64'(refresh_en), 64'(0));
      chk("arst timeout_err", 64'(timeout_err), 64'(0));
      @(negedge clk_sys);
      rst    = 1'b0;
      m_last = NREQ - 1;
      m_terr = 1'b0;
      m_addr = '0;
      exp_q.delete();
      run_one(0, 0, $urandom, M_KEEP);
      run_one(2, 1, $urandom, M_KEEP);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
